student_fir_mc: RTL and testbench
=================================

STUDENT_FIR_MC -- requirements
Module: student_fir_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent channels with separate sample histories.
REQ-002 SHALL have parameter NUM_TAPS, default 16, number of taps; the coefficient set is shared by all channels.
REQ-003 SHALL have parameter DATA_W, default 16, signed sample width.
REQ-004 SHALL have parameter COEFF_W, default 16, signed coefficient width.
REQ-005 SHALL have parameter ACC_W, default 40, accumulator width; elaboration fails unless ACC_W >= DATA_W+COEFF_W+$clog2(NUM_TAPS).
REQ-006 SHALL have parameter OUT_W, default 16, signed output width.
REQ-007 SHALL have parameter SHIFT, default 15, right-shift applied to the accumulator before saturation.
REQ-008 SHALL have ports (CW=max(1,$clog2(NUM_CH)), TW=$clog2(NUM_TAPS)):
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  sample offered.
- in_ready_o  out  1  sample can be accepted.
- in_ch_i  in  CW  channel of the offered sample.
- in_data_i  in  DATA_W  signed sample.
- coef_we_i  in  1  coefficient write strobe.
- coef_addr_i  in  TW  tap index.
- coef_data_i  in  COEFF_W  signed coefficient.
- clear_i  in  1  zero all sample histories.
- out_valid_o  out  1  result available.
- out_ready_i  in  1  consumer takes result.
- out_ch_o  out  CW  channel of the result.
- out_data_o  out  OUT_W  signed filtered sample.
- out_sat_o  out  1  result was saturated.
- busy_o  out  1  state is not IDLE.

Function
REQ-009 SHALL implement states IDLE, MAC, ROUND, OUT; busy_o=1 in every state except IDLE.
REQ-010 SHALL drive in_ready_o = (state==IDLE) & ~clear_i, combinationally.
REQ-011 SHALL, on an accept edge (in_valid_i & in_ready_o):
- write in_data_i to history[in_ch_i][wr_ptr[in_ch_i]];
- capture the channel number;
- clear the accumulator;
- enter MAC.
REQ-012 SHALL, in MAC, perform one MAC per cycle for k=0..NUM_TAPS-1: acc += x[n-k]*h[k], where x[n-k] = history[ch][(wr_ptr[ch]-k) mod NUM_TAPS]; full-precision signed product; then enter ROUND.
REQ-013 SHALL advance wr_ptr[ch] by one on leaving MAC, wrapping NUM_TAPS-1 -> 0.
REQ-014 SHALL, in ROUND, compute r = (acc + 2^(SHIFT-1)) >>> SHIFT (no rounding term when SHIFT=0), arithmetic shift.
REQ-015 SHALL, in ROUND, saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1], register it to out_data_o, set out_sat_o=1 if clipping occurred, and enter OUT.
REQ-016 SHALL hold out_valid_o=1 in OUT, keeping out_data_o/out_ch_o/out_sat_o stable until out_ready_i=1; then return to IDLE with out_valid_o=0 on the next edge.
REQ-017 SHALL raise out_valid_o on the (NUM_TAPS+2)th rising edge after the accept edge when there is no backpressure (18 cycles at default).
REQ-018 SHALL discard a sample accepted with in_ch_i >= NUM_CH: no history write, no output, state stays IDLE.
REQ-019 SHALL write coefficients only when coef_we_i=1 and state==IDLE; writes while busy_o=1, or with coef_addr_i >= NUM_TAPS, SHALL be ignored.
REQ-020 SHALL, when a coefficient write and a sample accept occur on the same edge, apply the new coefficient to that sample's computation.
REQ-021 SHALL, when clear_i=1 in IDLE, zero all histories and wr_ptrs on that edge with no sample accepted; clear_i while busy SHALL be ignored.

Reset
REQ-022 SHALL, on rst_i, immediately reset:
- state to IDLE;
- histories, coefficients, wr_ptrs and accumulator to 0;
- out_valid_o, out_data_o, out_ch_o, out_sat_o to 0.
REQ-023 SHALL abort any in-flight computation on reset mid-operation, produce no output, and accept a sample on the first edge after rst_i deasserts.

Verification
REQ-024 Impulse test:
- stimulus: h[k]=1024*(k+1); ch0 sample 0x4000, then 16 zeros;
- response: outputs 512, 1024, ..., 8192, then 0; out_sat_o=0; first out_valid_o 18 cycles after accept.
REQ-025 Channel isolation test:
- stimulus: same coefficients; alternate ch1 impulse/zeros with ch0 zeros;
- response: ch0 always 0; ch1 sequence as in REQ-024; out_ch_o matches the input channel.
REQ-026 Saturation test:
- stimulus: all h=0x7FFF; 16 samples of 0x7FFF;
- response: 16th output 0x7FFF with out_sat_o=1;
- then repeat with 16 samples of 0x8000: response 0x8000 with out_sat_o=1.
REQ-027 Rounding test:
- stimulus: h[0]=1, others 0; input 0x4000, then 0x3FFF;
- response: outputs 1, then 0.
REQ-028 Backpressure test:
- stimulus: out_ready_i=0 for 5 cycles in OUT, and concurrent in_valid_i=1 / coef_we_i=1;
- response: outputs stable; in_ready_o=0; coefficient unchanged; single handshake when out_ready_i rises.
REQ-029 Reset mid-MAC test:
- stimulus: assert rst_i in cycle 5 of MAC;
- response: out_valid_o never asserts; after release, an impulse with h[k]=1024*(k+1) rewritten yields 512 (history cleared).

Source files
------------

// File: rtl/student_fir_mc.sv
// student_fir_mc: multi-channel time-multiplexed FIR filter.
// One shared coefficient set, a private circular sample history per channel,
// and a single multiplier reused over NUM_TAPS cycles per accepted sample.
// Ports:
//   clk_i, rst_i              clock (rising edge), async active-high reset
//   in_valid_i/in_ready_o     sample handshake; in_ch_i selects the channel
//   in_data_i                 signed input sample
//   coef_we_i/addr/data       coefficient write port (honoured only when idle)
//   clear_i                   zero all histories and write pointers (idle only)
//   out_valid_o/out_ready_i   result handshake
//   out_ch_o, out_data_o      channel and rounded, saturated result
//   out_sat_o                 result was clipped
//   busy_o                    a computation is in flight
module student_fir_mc #(
  parameter int NUM_CH   = 2,
  parameter int NUM_TAPS = 16,
  parameter int DATA_W   = 16,
  parameter int COEFF_W  = 16,
  parameter int ACC_W    = 40,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 15,
  localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int TW      = $clog2(NUM_TAPS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [CW-1:0]             in_ch_i,
  input  logic signed [DATA_W-1:0]  in_data_i,
  input  logic                      coef_we_i,
  input  logic [TW-1:0]             coef_addr_i,
  input  logic signed [COEFF_W-1:0] coef_data_i,
  input  logic                      clear_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [CW-1:0]             out_ch_o,
  output logic signed [OUT_W-1:0]   out_data_o,
  output logic                      out_sat_o,
  output logic                      busy_o
);

  if (ACC_W < DATA_W + COEFF_W + $clog2(NUM_TAPS)) begin : g_acc_w_chk
    $error("student_fir_mc: ACC_W too narrow for the full-precision sum");
  end
  if (NUM_TAPS < 2) begin : g_taps_chk
    $error("student_fir_mc: NUM_TAPS must be at least 2");
  end
  if (OUT_W > ACC_W) begin : g_out_w_chk
    $error("student_fir_mc: OUT_W must not exceed ACC_W");
  end

  localparam int PW = DATA_W + COEFF_W;
  localparam int RB = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [TW:0] NT = (TW+1)'(NUM_TAPS);
  localparam logic signed [ACC_W:0] RND = (SHIFT > 0) ? ((ACC_W+1)'(1) << RB) : '0;
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0]  hist [NUM_CH][NUM_TAPS];
  logic signed [COEFF_W-1:0] coef [NUM_TAPS];
  logic [TW-1:0]             wr_ptr [NUM_CH];
  logic [CW-1:0]             ch_q;
  logic [TW:0]               tap;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   acc;

  logic                      ch_ok;
  logic                      addr_ok;
  logic                      accept;
  logic [TW-1:0]             rd_idx;
  logic signed [ACC_W:0]     rnd_sum;
  logic signed [ACC_W:0]     shifted;
  logic signed [OUT_W-1:0]   sat_val;
  logic                      clip;

  assign ch_ok       = int'(in_ch_i) < NUM_CH;
  assign addr_ok     = int'(coef_addr_i) < NUM_TAPS;
  assign in_ready_o  = (state == IDLE) & ~clear_i;
  assign accept      = in_valid_i & in_ready_o & ch_ok;
  assign busy_o      = (state != IDLE);
  assign out_valid_o = (state == OUT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (tap == NT) state_nxt = ROUND;
      ROUND:   state_nxt = OUT;
      OUT:     if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Circular read index (wr_ptr - tap) mod NUM_TAPS, valid for any tap count.
  always_comb begin
    rd_idx = '0;
    if ({1'b0, wr_ptr[ch_q]} >= tap) rd_idx = TW'({1'b0, wr_ptr[ch_q]} - tap);
    else                             rd_idx = TW'({1'b0, wr_ptr[ch_q]} + NT - tap);
  end

  always_comb begin
    rnd_sum = {acc[ACC_W-1], acc} + RND;
    shifted = rnd_sum >>> SHIFT;
    sat_val = shifted[OUT_W-1:0];
    clip    = 1'b0;
    if (shifted > MAXV) begin
      sat_val = OUT_MAX;
      clip    = 1'b1;
    end else if (shifted < MINV) begin
      sat_val = OUT_MIN;
      clip    = 1'b1;
    end
  end

  // The multiplier output is registered, so MAC runs NUM_TAPS+1 cycles: the
  // product of tap k is accumulated while tap k+1 is being multiplied, and the
  // final cycle only drains the last product.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        for (int unsigned t = 0; t < NUM_TAPS; t++) hist[c][t] <= '0;
      end
      for (int unsigned t = 0; t < NUM_TAPS; t++) coef[t] <= '0;
      ch_q       <= '0;
      tap        <= '0;
      prod       <= '0;
      acc        <= '0;
      out_data_o <= '0;
      out_ch_o   <= '0;
      out_sat_o  <= 1'b0;
    end else begin
      if (state == IDLE && coef_we_i && addr_ok) coef[coef_addr_i] <= coef_data_i;
      case (state)
        IDLE: begin
          if (clear_i) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
              wr_ptr[c] <= '0;
              for (int unsigned t = 0; t < NUM_TAPS; t++) hist[c][t] <= '0;
            end
          end else if (in_valid_i && ch_ok) begin
            hist[in_ch_i][wr_ptr[in_ch_i]] <= in_data_i;
            ch_q <= in_ch_i;
            acc  <= '0;
            prod <= '0;
            tap  <= '0;
          end
        end
        MAC: begin
          if (tap != NT) begin
            prod <= hist[ch_q][rd_idx] * coef[tap[TW-1:0]];
            tap  <= tap + (TW+1)'(1);
          end
          if (tap != '0) acc <= acc + ACC_W'(prod);
          if (tap == NT) begin
            if (wr_ptr[ch_q] == TW'(NUM_TAPS-1)) wr_ptr[ch_q] <= '0;
            else                                 wr_ptr[ch_q] <= wr_ptr[ch_q] + TW'(1);
          end
        end
        ROUND: begin
          out_data_o <= sat_val;
          out_sat_o  <= clip;
          out_ch_o   <= ch_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_student_fir_mc.sv
module tb_student_fir_mc;

  localparam int NCH = 2;
  localparam int NT  = 16;
  localparam int DW  = 16;
  localparam int CWD = 16;
  localparam int AW  = 40;
  localparam int OW  = 16;
  localparam int SH  = 15;
  localparam longint OMAX = (64'sd1 <<< (OW-1)) - 1;
  localparam longint OMIN = -(64'sd1 <<< (OW-1));

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [0:0]            in_ch;
  logic signed [DW-1:0]  in_data;
  logic                  coef_we;
  logic [3:0]            coef_addr;
  logic signed [CWD-1:0] coef_data;
  logic                  clear;
  logic                  out_valid;
  logic                  out_ready;
  logic [0:0]            out_ch;
  logic signed [OW-1:0]  out_data;
  logic                  out_sat;
  logic                  busy;

  student_fir_mc #(
    .NUM_CH(NCH), .NUM_TAPS(NT), .DATA_W(DW), .COEFF_W(CWD),
    .ACC_W(AW), .OUT_W(OW), .SHIFT(SH)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ch_i(in_ch), .in_data_i(in_data),
    .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_data_i(coef_data),
    .clear_i(clear),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_ch_o(out_ch),
    .out_data_o(out_data), .out_sat_o(out_sat), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     ch;
    longint data;
    bit     sat;
  } sb_t;

  sb_t    sb[$];
  longint mh [NCH][NT];
  longint mc [NT];
  int     mptr [NCH];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_clear_hist();
    for (int c = 0; c < NCH; c++) begin
      mptr[c] = 0;
      for (int t = 0; t < NT; t++) mh[c][t] = 0;
    end
  endfunction

  function automatic void model_accept(int ch, longint d);
    longint acc;
    longint r;
    sb_t    e;
    mh[ch][mptr[ch]] = d;
    acc = 0;
    for (int k = 0; k < NT; k++) acc += mh[ch][(mptr[ch] - k + NT) % NT] * mc[k];
    mptr[ch] = (mptr[ch] + 1) % NT;
    r = (acc + (64'sd1 <<< (SH-1))) >>> SH;
    e.ch  = ch;
    e.sat = 1'b0;
    if (r > OMAX) begin r = OMAX; e.sat = 1'b1; end
    else if (r < OMIN) begin r = OMIN; e.sat = 1'b1; end
    e.data = r;
    sb.push_back(e);
  endfunction

  task automatic write_coef(input int a, input longint d);
    coef_we   = 1'b1;
    coef_addr = 4'(a);
    coef_data = CWD'(d);
    @(posedge clk);
    mc[a] = d;
    #1;
    coef_we = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1;
    chk("clear_blocks_ready", in_ready, 0);
    @(posedge clk);
    model_clear_hist();
    #1;
    clear = 1'b0;
  endtask

  task automatic accept_sample(input int ch, input logic signed [DW-1:0] d,
                               input bit cw, input int ca, input longint cd);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_before_accept", in_ready, 1);
    in_valid  = 1'b1;
    in_ch     = 1'(ch);
    in_data   = d;
    coef_we   = cw;
    coef_addr = 4'(ca);
    coef_data = CWD'(cd);
    @(posedge clk);
    if (cw) mc[ca] = cd;
    model_accept(ch, longint'(d));
    #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic wait_output(input bit check_lat, output longint exp_data);
    int  n = 0;
    sb_t e;
    exp_data = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("out_valid_timeout", out_valid, 1);
    if (check_lat) chk("latency", n, NT + 2);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      exp_data = e.data;
      chk("out_data", $signed(out_data), e.data);
      chk("out_ch", out_ch, e.ch);
      chk("out_sat", out_sat, e.sat);
    end
    if (out_ready) begin
      @(posedge clk);
      #1;
      chk("out_valid_drop", out_valid, 0);
    end
  endtask

  task automatic run(input int ch, input logic signed [DW-1:0] d, output longint got);
    accept_sample(ch, d, 1'b0, 0, 0);
    wait_output(1'b1, got);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    longint got;
    longint exp_bp;
    bit     seen;

    rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; clear = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < NT; t++) mc[t] = 0;
    model_clear_hist();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_sat", out_sat, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Impulse response
    for (int k = 0; k < NT; k++) write_coef(k, 1024 * (k + 1));
    run(0, 16'sh4000, got);
    chk("impulse_0", got, 512);
    for (int i = 1; i <= NT; i++) begin
      run(0, 16'sh0000, got);
      chk("impulse_tail", got, (i < NT) ? 512 * (i + 1) : 0);
    end

    // Channel isolation
    do_clear();
    for (int i = 0; i < NT; i++) begin
      run(1, (i == 0) ? 16'sh4000 : 16'sh0000, got);
      chk("iso_ch1", got, 512 * (i + 1));
      run(0, 16'sh0000, got);
      chk("iso_ch0", got, 0);
    end

    // Rounding
    do_clear();
    write_coef(0, 1);
    for (int k = 1; k < NT; k++) write_coef(k, 0);
    run(0, 16'sh4000, got);
    chk("round_half_up", got, 1);
    run(0, 16'sh3FFF, got);
    chk("round_below_half", got, 0);
    run(0, -16'sh4000, got);
    chk("round_neg_half", got, 0);

    // Saturation, both rails
    do_clear();
    for (int k = 0; k < NT; k++) write_coef(k, 32767);
    for (int i = 0; i < NT; i++) run(0, 16'sh7FFF, got);
    chk("sat_pos_value", got, 32767);
    chk("sat_pos_flag", out_sat, 1);
    do_clear();
    for (int i = 0; i < NT; i++) run(0, 16'sh8000, got);
    chk("sat_neg_value", got, -32768);
    chk("sat_neg_flag", out_sat, 1);

    // Backpressure with concurrent sample offer, coefficient write and clear
    do_clear();
    for (int k = 0; k < NT; k++) write_coef(k, 1024 * (k + 1));
    out_ready = 1'b0;
    accept_sample(0, 16'sh4000, 1'b0, 0, 0);
    wait_output(1'b1, exp_bp);
    chk("bp_expected", exp_bp, 512);
    in_valid = 1'b1; in_ch = 1'b0; in_data = 16'sh7777;
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'sh1234; clear = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid_held", out_valid, 1);
      chk("bp_data_stable", $signed(out_data), exp_bp);
      chk("bp_ch_stable", out_ch, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; coef_we = 1'b0; clear = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_handshake", out_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("bp_single_output", seen, 0);
    run(0, 16'sh4000, got);
    chk("bp_coef_and_hist_kept", got, 1536);

    // Coefficient write on the accept edge applies to that sample
    do_clear();
    accept_sample(0, 16'sh4000, 1'b1, 0, 2048);
    wait_output(1'b1, got);
    chk("same_edge_coef", got, 1024);

    // Reset in cycle 5 of MAC
    accept_sample(0, 16'sh4000, 1'b0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    sb.delete();
    for (int t = 0; t < NT; t++) mc[t] = 0;
    model_clear_hist();
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    rst = 1'b0;
    accept_sample(1, 16'sh4000, 1'b0, 0, 0);
    wait_output(1'b1, got);
    chk("post_rst_zero_coef", got, 0);
    for (int i = 0; i < 25; i++) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk("midrst_no_output", seen, 0);
    for (int k = 0; k < NT; k++) write_coef(k, 1024 * (k + 1));
    run(0, 16'sh4000, got);
    chk("post_rst_impulse", got, 512);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
